instr_decode_stage: RTL and testbench

- Decode stage directly upstream of the immediate sign/zero extender.
- Accepts fetched instruction words and their PC over a valid/ready handshake, buffers them in a 2-entry skid buffer, and splits the head entry into MIPS fields.
- Produces `imm16` and `ext_sel`, which drive the extender's `extend`/`extSel` inputs, plus register addresses and write control for the register file and control unit.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/instr_decode_stage_if.sv | 43 ++++
 rtl/instr_field_decode.sv | 63 ++++++
 rtl/instr_decode_stage.sv | 90 +++++++++
 tb/tb_instr_decode_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcode/funct encodings and skid-buffer state encoding shared by
//           the decode stage.   Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Logical immediates are zero-extended; everything else is sign-extended.
   function automatic logic is_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode_stage_if.sv
// ============================================================================
// instr_decode_stage_if : fetch-side handshake plus decoded head outputs.
//                         Rev 1.0
// ============================================================================
`default_nettype none

interface instr_decode_stage_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [ADDR_W-1:0] in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm16;
   logic              ext_sel;
   logic [25:0]       jtarget;
   logic [4:0]        dst_reg;
   logic              reg_write;
   logic              illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
             imm16, ext_sel, jtarget, dst_reg, reg_write, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
             imm16, ext_sel, jtarget, dst_reg, reg_write, illegal
   );
endinterface

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
// instr_field_decode : combinational split of a MIPS word into fields and
//                      register-write control.   Rev 1.0
// ============================================================================
`default_nettype none

module instr_field_decode
   import cpu_pkg::*;
#(
   parameter logic [4:0] RA_REG = 5'd31
) (
   input  wire logic [31:0] instr,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      imm16,
   output logic             ext_sel,
   output logic [25:0]      jtarget,
   output logic [4:0]       dst_reg,
   output logic             reg_write,
   output logic             illegal
);
   logic w_wr_raw;

   assign opcode  = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign shamt   = instr[10:6];
   assign funct   = instr[5:0];
   assign imm16   = instr[15:0];
   assign jtarget = instr[25:0];
   assign ext_sel = is_zero_ext(opcode);

   always_comb begin
      w_wr_raw = 1'b0;
      illegal  = 1'b0;
      dst_reg  = rt;
      case (opcode)
         OP_RTYPE: begin
            dst_reg  = rd;
            w_wr_raw = (funct != FUNCT_JR);
         end
         OP_JAL: begin
            dst_reg  = RA_REG;
            w_wr_raw = 1'b1;
         end
         OP_J, OP_BEQ, OP_BNE, OP_SW: w_wr_raw = 1'b0;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: w_wr_raw = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   // $zero is never a real write target.
   assign reg_write = w_wr_raw && !illegal && (dst_reg != 5'd0);

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// ============================================================================
// instr_decode_stage : 2-entry skid buffer feeding a combinational field
//                      decoder on the head entry.   Rev 1.0
// ============================================================================
`default_nettype none

module instr_decode_stage
   import cpu_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter logic [4:0] RA_REG = 5'd31
) (
   input  wire logic           clk,
   input  wire logic           reset,
   input  wire logic           flush,
   instr_decode_stage_if.slave bus
);
   logic [1:0]        r_state;
   logic [31:0]       r_head;
   logic [31:0]       r_skid;
   logic [ADDR_W-1:0] r_head_pc;
   logic [ADDR_W-1:0] r_skid_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_EMPTY;
         r_head    <= '0;
         r_skid    <= '0;
         r_head_pc <= '0;
         r_skid_pc <= '0;
      end else if (flush) begin
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (bus.in_valid) begin
                  r_head    <= bus.in_instr;
                  r_head_pc <= bus.in_pc;
                  r_state   <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (bus.in_valid && bus.out_ready) begin
                  r_head    <= bus.in_instr;
                  r_head_pc <= bus.in_pc;
               end else if (bus.in_valid) begin
                  r_skid    <= bus.in_instr;
                  r_skid_pc <= bus.in_pc;
                  r_state   <= ST_TWO;
               end else if (bus.out_ready) begin
                  r_state   <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (bus.out_ready) begin
                  r_head    <= r_skid;
                  r_head_pc <= r_skid_pc;
                  r_state   <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.in_ready  = (r_state != ST_TWO);
   assign bus.out_valid = (r_state != ST_EMPTY);
   assign bus.out_pc    = r_head_pc;

   instr_field_decode #(
      .RA_REG (RA_REG)
   ) u_field_decode (
      .instr     (r_head),
      .opcode    (bus.opcode),
      .rs        (bus.rs),
      .rt        (bus.rt),
      .rd        (bus.rd),
      .shamt     (bus.shamt),
      .funct     (bus.funct),
      .imm16     (bus.imm16),
      .ext_sel   (bus.ext_sel),
      .jtarget   (bus.jtarget),
      .dst_reg   (bus.dst_reg),
      .reg_write (bus.reg_write),
      .illegal   (bus.illegal)
   );

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// ============================================================================
// tb_instr_decode_stage : directed vectors against hand-computed values.
//                         Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_decode_stage;
   logic clk;
   logic reset;
   logic flush;
   int   checks;
   int   failures;

   instr_decode_stage_if #(.ADDR_W(32)) bus ();

   instr_decode_stage #(
      .ADDR_W (32),
      .RA_REG (5'd31)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Downstream extender behaviour, used to confirm the selected extension.
   function automatic logic [31:0] extend(input logic [15:0] imm, input logic sel);
      return sel ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] w, input logic [31:0] pc);
      bus.in_valid = v;
      bus.in_instr = w;
      bus.in_pc    = pc;
   endtask

   // Load one word through an empty stage; returns with it at the head.
   task automatic load_one(input logic [31:0] w, input logic [31:0] pc);
      bus.out_ready = 1'b1;
      offer(1'b1, w, pc);
      step();
      offer(1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; flush = 1'b0;
      bus.out_ready = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      step(); step();
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         check("idle_out_valid", bus.out_valid, 0);
         check("idle_in_ready",  bus.in_ready,  1);
         check("idle_ext_sel",   bus.ext_sel,   0);
         check("idle_reg_write", bus.reg_write, 0);
         check("idle_dst_reg",   bus.dst_reg,   0);
         step();
      end

      // addi then ori, back to back
      bus.out_ready = 1'b1;
      offer(1'b1, 32'h2065FFF8, 32'h100);
      step();
      check("addi_valid",   bus.out_valid, 1);
      check("addi_pc",      bus.out_pc,    32'h100);
      check("addi_imm16",   bus.imm16,     16'hFFF8);
      check("addi_ext_sel", bus.ext_sel,   0);
      check("addi_dst",     bus.dst_reg,   5);
      check("addi_rs",      bus.rs,        3);
      check("addi_wr",      bus.reg_write, 1);
      check("addi_extend",  extend(bus.imm16, bus.ext_sel), 32'hFFFFFFF8);
      offer(1'b1, 32'h3465FFF8, 32'h104);
      step();
      check("ori_valid",   bus.out_valid, 1);
      check("ori_pc",      bus.out_pc,    32'h104);
      check("ori_ext_sel", bus.ext_sel,   1);
      check("ori_wr",      bus.reg_write, 1);
      check("ori_extend",  extend(bus.imm16, bus.ext_sel), 32'h0000FFF8);
      offer(1'b0, 32'h0, 32'h0);
      step();
      check("drain_valid", bus.out_valid, 0);

      // backpressure: three words offered, two accepted
      bus.out_ready = 1'b0;
      offer(1'b1, 32'h20010001, 32'h200);
      step();
      check("bp_a_in_ready", bus.in_ready, 1);
      check("bp_a_pc",       bus.out_pc,   32'h200);
      offer(1'b1, 32'h20020002, 32'h204);
      step();
      check("bp_full_in_ready", bus.in_ready, 0);
      check("bp_head_pc",       bus.out_pc,   32'h200);
      offer(1'b1, 32'h20030003, 32'h208);
      step(); step();
      check("bp_hold_pc",    bus.out_pc,   32'h200);
      check("bp_hold_imm",   bus.imm16,    16'h0001);
      check("bp_hold_dst",   bus.dst_reg,  1);
      check("bp_hold_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      step();
      check("bp_b_pc",       bus.out_pc,   32'h204);
      check("bp_b_imm",      bus.imm16,    16'h0002);
      check("bp_b_in_ready", bus.in_ready, 1);
      step();
      check("bp_c_pc",    bus.out_pc,    32'h208);
      check("bp_c_imm",   bus.imm16,     16'h0003);
      check("bp_c_valid", bus.out_valid, 1);
      offer(1'b0, 32'h0, 32'h0);
      step();
      check("bp_empty", bus.out_valid, 0);

      // flush while full, with an input offered the same cycle
      bus.out_ready = 1'b0;
      offer(1'b1, 32'h20040004, 32'h300);
      step();
      offer(1'b1, 32'h20050005, 32'h304);
      step();
      check("fl_full", bus.in_ready, 0);
      flush = 1'b1;
      offer(1'b1, 32'h20060006, 32'h308);
      step();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      check("fl_out_valid", bus.out_valid, 0);
      check("fl_in_ready",  bus.in_ready,  1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_no_emerge", bus.out_valid, 0);
      end

      // decode corner cases
      load_one(32'h0C000010, 32'h400);
      check("jal_dst",     bus.dst_reg,   31);
      check("jal_wr",      bus.reg_write, 1);
      check("jal_jtarget", bus.jtarget,   26'h0000010);
      check("jal_illegal", bus.illegal,   0);
      step();
      load_one(32'h03E00008, 32'h404);
      check("jr_wr",      bus.reg_write, 0);
      check("jr_rs",      bus.rs,        31);
      check("jr_illegal", bus.illegal,   0);
      step();
      load_one(32'hFC000000, 32'h408);
      check("bad_illegal", bus.illegal,   1);
      check("bad_wr",      bus.reg_write, 0);
      step();
      load_one(32'hFC050000, 32'h40C);
      check("bad_rt_illegal", bus.illegal,   1);
      check("bad_rt_dst",     bus.dst_reg,   5);
      check("bad_rt_wr",      bus.reg_write, 0);
      step();
      load_one(32'h00221820, 32'h410);
      check("add_dst",     bus.dst_reg,   3);
      check("add_wr",      bus.reg_write, 1);
      check("add_funct",   bus.funct,     6'h20);
      check("add_ext_sel", bus.ext_sel,   0);
      step();
      load_one(32'h8C430004, 32'h414);
      check("lw_dst", bus.dst_reg,   3);
      check("lw_wr",  bus.reg_write, 1);
      step();
      load_one(32'hAC430004, 32'h418);
      check("sw_wr",      bus.reg_write, 0);
      check("sw_illegal", bus.illegal,   0);
      step();
      load_one(32'h3C051234, 32'h41C);
      check("lui_ext_sel", bus.ext_sel,   1);
      check("lui_dst",     bus.dst_reg,   5);
      check("lui_extend",  extend(bus.imm16, bus.ext_sel), 32'h00001234);
      step();
      load_one(32'h10220003, 32'h420);
      check("beq_wr",      bus.reg_write, 0);
      check("beq_illegal", bus.illegal,   0);
      check("beq_ext_sel", bus.ext_sel,   0);
      step();

      // reset while full discards everything
      bus.out_ready = 1'b0;
      offer(1'b1, 32'h20070007, 32'h500);
      step();
      offer(1'b1, 32'h20080008, 32'h504);
      step();
      reset = 1'b1;
      offer(1'b0, 32'h0, 32'h0);
      step();
      reset = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_imm16",     bus.imm16,     0);
      check("rst_pc",        bus.out_pc,    0);
      bus.out_ready = 1'b1;
      step();
      check("rst_no_pulse", bus.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
